conv1_frame_ctrl: RTL and testbench

Frame sequencer for the first convolution stage. On a start pulse it reads one IMG_WIDTH×IMG_WIDTH 8-bit image from a synchronous-read image buffer and streams it, one pixel per enabled cycle, into the conv1 core's `valid_in`/`pixel_in`. It then counts the core's `result_valid` pulses, tagging each with its output row/column, and reports frame completion. It sits between the image buffer / host control registers and the conv1 core, and sequences the core once per frame.

---
 rtl/conv1_frame_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_conv1_frame_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/conv1_frame_ctrl.sv
// Frame sequencer for conv1: streams one image from the buffer into the core, then counts and tags results.
// Optional drain watchdog enabled by defining CONV1_CTRL_TIMEOUT_EN.
module conv1_frame_ctrl #(
   parameter int IMG_WIDTH      = 28,
   parameter int KERNEL         = 5,
   parameter int ADDR_WIDTH     = 10,
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  pix_hold,
   output logic                  img_rd_en,
   output logic [ADDR_WIDTH-1:0] img_addr,
   input  logic [DATA_WIDTH-1:0] img_rd_data,
   output logic                  core_valid,
   output logic [DATA_WIDTH-1:0] core_pixel,
   input  logic                  core_result_valid,
   output logic                  res_wr_en,
   output logic [4:0]            res_row,
   output logic [4:0]            res_col,
   output logic                  busy,
   output logic                  done,
   output logic                  err_overrun,
   output logic                  err_timeout
);
   // state   | meaning
   // S_IDLE  | waiting for start
   // S_FETCH | issuing buffer reads, one per cycle without pix_hold
   // S_DRAIN | all pixels sent, waiting for the remaining core results
   // S_DONE  | one-cycle frame-complete pulse
   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

   localparam int OUT_DIM = IMG_WIDTH - KERNEL + 1;
   localparam int NPIX    = IMG_WIDTH * IMG_WIDTH;
   localparam int NRES    = OUT_DIM * OUT_DIM;
   localparam int RW      = $clog2(NRES + 1);

   if ((2 ** ADDR_WIDTH) < NPIX || OUT_DIM > 32 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("conv1_frame_ctrl: parameter set not supported");
   end

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] pix_cnt_q, pix_cnt_d;
   logic [RW-1:0]         res_cnt_q, res_cnt_d;
   logic [4:0]            row_q, row_d, col_q, col_d;
   logic [4:0]            res_row_q, res_row_d, res_col_q, res_col_d;
   logic                  res_wr_en_q, res_wr_en_d;
   logic                  core_valid_q, core_valid_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  err_overrun_q, err_overrun_d;
   logic                  rd_en, counting, res_accept;
`ifdef CONV1_CTRL_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0]         drain_cnt_q, drain_cnt_d;
   logic                  err_timeout_q, err_timeout_d;
`endif

   always_comb begin
      state_d       = state_q;
      pix_cnt_d     = pix_cnt_q;
      res_cnt_d     = res_cnt_q;
      row_d         = row_q;
      col_d         = col_q;
      res_row_d     = res_row_q;
      res_col_d     = res_col_q;
      busy_d        = busy_q;
      err_overrun_d = err_overrun_q;
      res_wr_en_d   = 1'b0;
      done_d        = 1'b0;
`ifdef CONV1_CTRL_TIMEOUT_EN
      drain_cnt_d   = drain_cnt_q;
      err_timeout_d = err_timeout_q;
`endif
      rd_en        = (state_q == S_FETCH) && !pix_hold;
      core_valid_d = rd_en;
      counting     = (state_q == S_FETCH) || (state_q == S_DRAIN);
      res_accept   = counting && core_result_valid && (res_cnt_q != RW'(NRES));

      if (res_accept) begin
         res_wr_en_d = 1'b1;
         res_row_d   = row_q;
         res_col_d   = col_q;
         res_cnt_d   = res_cnt_q + RW'(1);
         if (col_q == 5'(OUT_DIM - 1)) begin
            col_d = '0;
            row_d = row_q + 5'd1;
         end else begin
            col_d = col_q + 5'd1;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d       = S_FETCH;
               busy_d        = 1'b1;
               pix_cnt_d     = '0;
               res_cnt_d     = '0;
               row_d         = '0;
               col_d         = '0;
               err_overrun_d = 1'b0;
`ifdef CONV1_CTRL_TIMEOUT_EN
               err_timeout_d = 1'b0;
`endif
            end
         end
         S_FETCH: begin
            if (rd_en) begin
               pix_cnt_d = pix_cnt_q + ADDR_WIDTH'(1);
               if (pix_cnt_q == ADDR_WIDTH'(NPIX - 1)) begin
                  state_d = S_DRAIN;
`ifdef CONV1_CTRL_TIMEOUT_EN
                  drain_cnt_d = '0;
`endif
               end
            end
         end
         S_DRAIN: begin
            // the final result completes the frame in the same cycle it arrives
            if (res_cnt_d == RW'(NRES)) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
`ifdef CONV1_CTRL_TIMEOUT_EN
            else begin
               drain_cnt_d = drain_cnt_q + TW'(1);
               if (drain_cnt_d == TW'(TIMEOUT_CYCLES)) begin
                  state_d       = S_DONE;
                  busy_d        = 1'b0;
                  done_d        = 1'b1;
                  err_timeout_d = 1'b1;
               end
            end
`endif
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (core_result_valid && !res_accept) err_overrun_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         pix_cnt_q     <= '0;
         res_cnt_q     <= '0;
         row_q         <= '0;
         col_q         <= '0;
         res_row_q     <= '0;
         res_col_q     <= '0;
         res_wr_en_q   <= 1'b0;
         core_valid_q  <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         err_overrun_q <= 1'b0;
`ifdef CONV1_CTRL_TIMEOUT_EN
         drain_cnt_q   <= '0;
         err_timeout_q <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         pix_cnt_q     <= pix_cnt_d;
         res_cnt_q     <= res_cnt_d;
         row_q         <= row_d;
         col_q         <= col_d;
         res_row_q     <= res_row_d;
         res_col_q     <= res_col_d;
         res_wr_en_q   <= res_wr_en_d;
         core_valid_q  <= core_valid_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         err_overrun_q <= err_overrun_d;
`ifdef CONV1_CTRL_TIMEOUT_EN
         drain_cnt_q   <= drain_cnt_d;
         err_timeout_q <= err_timeout_d;
`endif
      end
   end

   assign img_rd_en   = rd_en;
   assign img_addr    = pix_cnt_q;
   assign core_valid  = core_valid_q;
   // buffer output is already registered; gate it so the core sees 0 between pixels
   assign core_pixel  = core_valid_q ? img_rd_data : '0;
   assign res_wr_en   = res_wr_en_q;
   assign res_row     = res_row_q;
   assign res_col     = res_col_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err_overrun = err_overrun_q;
`ifdef CONV1_CTRL_TIMEOUT_EN
   assign err_timeout = err_timeout_q;
`else
   assign err_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_conv1_frame_ctrl.sv
// Scoreboard bench for conv1_frame_ctrl: stimulus queues expected reads/pixels/results, a monitor checks them.
module tb_conv1_frame_ctrl;
   localparam int NPIX = 784;
   localparam int NRES = 576;
   localparam int TO   = 4096;

   logic       clk, rst, start, pix_hold, core_result_valid;
   logic       img_rd_en, core_valid, res_wr_en, busy, done, err_overrun, err_timeout;
   logic [9:0] img_addr;
   logic [7:0] img_rd_data, core_pixel;
   logic [4:0] res_row, res_col;

   int n_vec = 0, n_err = 0, cyc = 0, exp_done = 0, done_cnt = 0;
   int         exp_addr_q[$];
   logic [7:0] exp_pix_q[$];
   int         exp_res_q[$];

   conv1_frame_ctrl #(.IMG_WIDTH(28), .KERNEL(5), .ADDR_WIDTH(10), .DATA_WIDTH(8),
                      .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .start(start), .pix_hold(pix_hold),
      .img_rd_en(img_rd_en), .img_addr(img_addr), .img_rd_data(img_rd_data),
      .core_valid(core_valid), .core_pixel(core_pixel),
      .core_result_valid(core_result_valid), .res_wr_en(res_wr_en),
      .res_row(res_row), .res_col(res_col), .busy(busy), .done(done),
      .err_overrun(err_overrun), .err_timeout(err_timeout));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] pix_of(input int a);
      return 8'((a * 7 + 3) % 256);
   endfunction

   // synchronous-read image buffer model
   always @(posedge clk) if (img_rd_en) img_rd_data <= pix_of(int'(img_addr));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (img_rd_en) begin
         if (exp_addr_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL read_addr: unexpected read of %0d, none required, cycle %0d", img_addr, cyc);
         end else chk("read_addr", 32'(img_addr), 32'(exp_addr_q.pop_front()));
      end
      if (core_valid) begin
         if (exp_pix_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL core_pixel: unexpected core_valid, pixel %0h, cycle %0d", core_pixel, cyc);
         end else chk("core_pixel", 32'(core_pixel), 32'(exp_pix_q.pop_front()));
      end
      if (res_wr_en) begin
         if (exp_res_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL res_wr_en: unexpected result row %0d col %0d, cycle %0d", res_row, res_col, cyc);
         end else chk("res_rowcol", 32'({res_row, res_col}), 32'(exp_res_q.pop_front()));
      end
      if (done) done_cnt++;
   end

   // Called at posedge+1 of the cycle in which start is to be driven.
   task automatic do_frame(input int hold_addr, input int hold_len, input int abort_at,
                           input int nres, input bit extra);
      int nread, holdleft, last, e_cyc;
      bit rd, prev_rd, first;
      last = (abort_at >= 0) ? abort_at : NPIX - 1;
      for (int a = 0; a <= last; a++) exp_addr_q.push_back(a);
      for (int a = 0; a < ((abort_at >= 0) ? abort_at : NPIX); a++) exp_pix_q.push_back(pix_of(a));
      start = 1'b1;
      tick();
      start = 1'b0;
      nread = 0; holdleft = hold_len; prev_rd = 1'b0; first = 1'b1;
      while (nread <= last) begin
         if (nread == hold_addr && holdleft > 0) begin
            pix_hold = 1'b1; rd = 1'b0; holdleft--;
         end else begin
            pix_hold = 1'b0; rd = 1'b1;
         end
         if (rd && abort_at >= 0 && nread == abort_at) rst = 1'b1;
         @(negedge clk);
         chk("img_rd_en", 32'(img_rd_en), 32'(rd));
         chk("core_valid", 32'(core_valid), 32'(prev_rd));
         if (first) begin
            chk("busy_at_start", 32'(busy), 1);
            chk("err_clear_at_start", 32'({err_overrun, err_timeout}), 0);
         end
         if (rd) nread++;
         prev_rd = rd;
         first = 1'b0;
         tick();
      end
      pix_hold = 1'b0;
      if (abort_at >= 0) begin
         rst = 1'b0;
         @(negedge clk);
         chk("abort_busy", 32'(busy), 0);
         chk("abort_addr", 32'(img_addr), 0);
         chk("abort_valids", 32'({img_rd_en, core_valid, res_wr_en}), 0);
         return;
      end
      e_cyc = cyc;
      @(negedge clk);
      chk("drain_last_valid", 32'(core_valid), 1);
      chk("drain_no_read", 32'(img_rd_en), 0);
      chk("drain_busy", 32'(busy), 1);
      tick();
      for (int i = 0; i < nres; i++) begin
         if (i % 7 == 6) begin
            core_result_valid = 1'b0;
            tick();
         end
         core_result_valid = 1'b1;
         exp_res_q.push_back((i / 24) * 32 + (i % 24));
         tick();
      end
      core_result_valid = 1'b0;
      if (nres == NRES) begin
         core_result_valid = extra;
         exp_done++;
         @(negedge clk);
         chk("done_pulse", 32'(done), 1);
         chk("busy_fall", 32'(busy), 0);
         tick();
         core_result_valid = 1'b0;
         @(negedge clk);
         chk("done_single", 32'(done), 0);
         chk("overrun_after_frame", 32'(err_overrun), 32'(extra));
      end else begin
`ifdef CONV1_CTRL_TIMEOUT_EN
         while (cyc < e_cyc + TO - 1) tick();
         @(negedge clk);
         chk("timeout_not_early", 32'(done), 0);
         tick();
         exp_done++;
         @(negedge clk);
         chk("timeout_done", 32'(done), 1);
         chk("timeout_flag", 32'(err_timeout), 1);
         chk("timeout_busy", 32'(busy), 0);
         tick();
`else
         repeat (300) tick();
         @(negedge clk);
         chk("stall_busy", 32'(busy), 1);
         chk("stall_no_done", 32'({done, err_timeout}), 0);
         tick();
         rst = 1'b1;
         tick();
         rst = 1'b0;
         @(negedge clk);
         chk("stall_reset_busy", 32'(busy), 0);
         tick();
`endif
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; pix_hold = 1'b0; core_result_valid = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      while (cyc < 10) begin
         @(negedge clk);
         chk("idle_ctrl", 32'({img_rd_en, core_valid, res_wr_en, busy, done, err_overrun, err_timeout}), 0);
         chk("idle_data", 32'({img_addr, core_pixel}), 0);
         chk("idle_res", 32'({res_row, res_col}), 0);
         tick();
      end

      do_frame(-1, 0, -1, NRES, 1'b0);
      tick();
      chk("no_overrun_yet", 32'(err_overrun), 0);
      tick();
      core_result_valid = 1'b1;
      tick();
      core_result_valid = 1'b0;
      @(negedge clk);
      chk("overrun_idle", 32'(err_overrun), 1);
      tick();

      do_frame(100, 3, -1, NRES, 1'b1);
      do_frame(-1, 0, 300, 0, 1'b0);
      do_frame(-1, 0, -1, NRES, 1'b0);
      tick();
      do_frame(-1, 0, -1, 500, 1'b0);

      repeat (3) tick();
      chk("addr_q_empty", 32'(exp_addr_q.size()), 0);
      chk("pix_q_empty", 32'(exp_pix_q.size()), 0);
      chk("res_q_empty", 32'(exp_res_q.size()), 0);
      chk("done_pulses", 32'(done_cnt), 32'(exp_done));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
